// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched on accept; HI/LO update on the final busy cycle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUctr,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } op_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          load, write_res, mthi, mtlo;

    logic [31:0]   a_q, b_q, hi_q, lo_q;
    op_t           op_q;

    logic [31:0]   mag_a, mag_b, uq, ur, q_s, r_s;
    logic [63:0]   prod_s, prod_u;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        load      = 1'b0;
        write_res = 1'b0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (MDUctr)
                        OP_MULT, OP_MULTU: begin
                            load    = 1'b1;
                            cnt_n   = CW'(MULT_CYCLES);
                            state_n = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            load    = 1'b1;
                            cnt_n   = CW'(DIV_CYCLES);
                            state_n = RUN;
                        end
                        OP_MTHI: mthi = 1'b1;
                        OP_MTLO: mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    write_res = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Signed division via magnitudes: truncation toward zero falls out naturally,
    // and 0x80000000 / -1 yields 0x80000000 without a special case.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        mag_a  = (op_q == OP_DIV && a_q[31]) ? (~a_q + 32'd1) : a_q;
        mag_b  = (op_q == OP_DIV && b_q[31]) ? (~b_q + 32'd1) : b_q;
        uq     = '0;
        ur     = '0;
        if (mag_b != '0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        q_s = (a_q[31] ^ b_q[31]) ? (~uq + 32'd1) : uq;
        r_s = a_q[31] ? (~ur + 32'd1) : ur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_NONE;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (load) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op_t'(MDUctr);
            end
            if (mthi) hi_q <= A;
            if (mtlo) lo_q <= A;
            if (write_res) begin
                case (op_q)
                    OP_MULT:  {hi_q, lo_q} <= prod_s;
                    OP_MULTU: {hi_q, lo_q} <= prod_u;
                    OP_DIV: if (b_q != '0) begin
                        lo_q <= q_s;
                        hi_q <= r_s;
                    end
                    OP_DIVU: if (b_q != '0) begin
                        lo_q <= uq;
                        hi_q <= ur;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO and busy length are queued
// at issue and popped when the operation completes.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUctr;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi, m_lo;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUctr(MDUctr),
        .start(start), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one op for a single accept edge, then scramble the inputs.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int cyc);
        exp_t e;
        @(negedge clk);
        A = a; B = b; MDUctr = op; start = 1'b1;
        e.tag = tag; e.hi = ehi; e.lo = elo; e.cycles = cyc;
        sb.push_back(e);
        m_hi = ehi; m_lo = elo;
        @(posedge clk); #1;
        start = 1'b0; MDUctr = 4'd0; A = $urandom; B = $urandom;
    endtask

    // Count remaining busy edges (bounded), then compare against the queue head.
    task automatic finish_op(input int already);
        exp_t e;
        int   n;
        n = already;
        while (busy === 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        check({e.tag, " busy cycles"}, 32'(n), 32'(e.cycles));
        check({e.tag, " HI"}, HI, e.hi);
        check({e.tag, " LO"}, LO, e.lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] p;
        reset = 1'b1; A = '0; B = '0; MDUctr = '0; start = 1'b0;
        m_hi = '0; m_lo = '0;
        #12;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        reset = 1'b0;

        issue("mthi", 4'd5, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 0);
        finish_op(0);

        issue("mult", 4'd1, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        finish_op(0);

        issue("div", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        finish_op(0);
        issue("divu", 4'd4, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, 10);
        finish_op(0);

        // MTLO presented while busy must be ignored
        issue("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        @(negedge clk);
        A = 32'hDEADBEEF; MDUctr = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; MDUctr = 4'd0;
        check("multu busy held", {31'b0, busy}, 32'd1);
        finish_op(1);
        repeat (2) @(posedge clk); #1;
        check("mtlo ignored LO", LO, 32'h00000001);

        issue("mthi5", 4'd5, 32'd5, 32'h0, 32'd5, m_lo, 0);
        finish_op(0);
        issue("mtlo7", 4'd6, 32'd7, 32'h0, 32'd5, 32'd7, 0);
        finish_op(0);
        issue("div by zero", 4'd3, 32'd100, 32'd0, 32'd5, 32'd7, 10);
        finish_op(0);
        issue("divu by zero", 4'd4, 32'd100, 32'd0, 32'd5, 32'd7, 10);
        finish_op(0);
        issue("div overflow", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
        finish_op(0);

        // Random ops against behavioural expressions
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom_range(1, 32'h7FFFFFFF);
            p = 64'($signed(ra)) * 64'($signed(rb));
            issue("rnd mult", 4'd1, ra, rb, p[63:32], p[31:0], 5);
            finish_op(0);
            p = 64'(ra) * 64'(rb);
            issue("rnd multu", 4'd2, ra, rb, p[63:32], p[31:0], 5);
            finish_op(0);
            issue("rnd divu", 4'd4, ra, rb, ra % rb, ra / rb, 10);
            finish_op(0);
            issue("rnd div", 4'd3, ra, rb, 32'($signed(ra) % $signed(rb)),
                  32'($signed(ra) / $signed(rb)), 10);
            finish_op(0);
        end

        // Asynchronous reset partway through a divide
        issue("mtlo pre", 4'd6, 32'h00ABCDEF, 32'h0, m_hi, 32'h00ABCDEF, 0);
        finish_op(0);
        issue("div aborted", 4'd3, 32'd1000, 32'd7, 32'd6, 32'd142, 10);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort HI", HI, 32'd0);
        check("abort LO", LO, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        issue("mult after reset", 4'd1, 32'd2, 32'd2, 32'd0, 32'd4, 5);
        finish_op(0);
        repeat (12) @(posedge clk); #1;
        check("no stale HI", HI, 32'd0);
        check("no stale LO", LO, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
